// File: rtl/sisc_ctrl_gen_pkg.sv
// sisc_pkg: shared definitions for the SISC control generator.
// FSM state enumeration, opcode constants, ALU-op constants and an
// opcode normaliser that folds unknown opcodes onto NOP.
package sisc_pkg;

    typedef enum logic [2:0] {
        ST_START0    = 3'd0,
        ST_FETCH     = 3'd1,
        ST_DECODE    = 3'd2,
        ST_EXECUTE   = 3'd3,
        ST_MEM       = 3'd4,
        ST_WRITEBACK = 3'd5,
        ST_HALT      = 3'd6
    } state_t;

    localparam logic [3:0] OP_NOP     = 4'b0000;
    localparam logic [3:0] OP_ALU_RR  = 4'b0001;
    localparam logic [3:0] OP_ALU_IMM = 4'b0010;
    localparam logic [3:0] OP_LOAD    = 4'b1000;
    localparam logic [3:0] OP_STORE   = 4'b1100;
    localparam logic [3:0] OP_BRA     = 4'b0100;
    localparam logic [3:0] OP_BNE     = 4'b0101;
    localparam logic [3:0] OP_HALT    = 4'b1111;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_OR  = 2'b11;

    // Unknown opcodes behave exactly like NOP, so they are stored as NOP.
    function automatic logic [3:0] norm_op(input logic [3:0] op);
        case (op)
            OP_NOP, OP_ALU_RR, OP_ALU_IMM, OP_LOAD,
            OP_STORE, OP_BRA, OP_BNE, OP_HALT: norm_op = op;
            default:                          norm_op = OP_NOP;
        endcase
    endfunction

endpackage

// File: rtl/sisc_ctrl_gen_cond_eval.sv
// sisc_cond_eval: branch condition evaluation.
// BRA is taken when any masked status flag is set (an all-zero mask means
// unconditional); BNE is taken when no masked flag is set. Other opcodes
// never branch.
module sisc_cond_eval
    import sisc_pkg::*;
#(
    parameter int STAT_W = 4
) (
    input  logic [STAT_W-1:0] stat,
    input  logic [STAT_W-1:0] mask,
    input  logic [3:0]        opcode,
    output logic              taken
);

    logic hit;

    // Combine masked flags with the branch flavour.
    always_comb begin
        taken = 1'b0;
        hit   = |(stat & mask);
        case (opcode)
            OP_BRA:  taken = (mask == '0) || hit;
            OP_BNE:  taken = !hit;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/sisc_ctrl_gen.sv
// sisc_ctrl_gen: multi-cycle control FSM for the SISC processor.
// Sequence: START0 -> FETCH -> DECODE -> EXECUTE -> {MEM} -> {WRITEBACK} -> FETCH,
// with HALT absorbing until reset. Every control output is a register loaded
// from a decode of the *next* state and the *next* latched opcode, so the
// outputs line up with the state they belong to while remaining glitch-free.
// The instruction is only looked at while in DECODE.
// Optional feature macro: SISC_CTRL_MEMWAIT_EN -- MEM holds until mem_rdy.
// mem_rdy handshake: the controller presents dm_re/dm_we during MEM; a cycle in
// MEM with mem_rdy=1 completes the access and MEM is left at the next edge.
module sisc_ctrl_gen
    import sisc_pkg::*;
#(
    parameter int IR_W    = 32,
    parameter int STAT_W  = 4,
    parameter int ALUOP_W = 2
) (
    input  logic               clk,
    input  logic               rst_f,
    input  logic [IR_W-1:0]    ir,
    input  logic [STAT_W-1:0]  stat,
    input  logic               mem_rdy,
    output logic               ir_load,
    output logic               pc_write,
    output logic               pc_sel,
    output logic               br_sel,
    output logic               rf_we,
    output logic               wb_sel,
    output logic               stat_en,
    output logic               rb_sel,
    output logic               mm_sel,
    output logic               dm_we,
    output logic               dm_re,
    output logic [ALUOP_W-1:0] alu_op,
    output logic [2:0]         state,
    output logic               halted
);

    state_t state_q, state_d;
    logic [3:0] op_q, op_d;

    logic [3:0]        ir_op;
    logic [STAT_W-1:0] ir_mask;
    logic              ir_br;
    logic              taken;

    logic               ir_load_d, pc_write_d, pc_sel_d, br_sel_d;
    logic               rf_we_d, wb_sel_d, stat_en_d, rb_sel_d;
    logic               mm_sel_d, dm_we_d, dm_re_d, halted_d;
    logic [ALUOP_W-1:0] alu_op_d;

    assign ir_op   = ir[IR_W-1 -: 4];
    assign ir_mask = ir[IR_W-5 -: STAT_W];
    assign ir_br   = ir[IR_W-5-STAT_W];
    assign state   = state_q;

`ifndef SISC_CTRL_MEMWAIT_EN
    logic unused_rdy;
    assign unused_rdy = mem_rdy;
`endif
    logic unused_ir;
    assign unused_ir = ^ir;

    // Latched opcode follows ir only while decoding; elsewhere it holds.
    always_comb begin
        op_d = op_q;
        if (state_q == ST_DECODE) op_d = norm_op(ir_op);
    end

    sisc_cond_eval #(.STAT_W(STAT_W)) u_cond_eval (
        .stat   (stat),
        .mask   (ir_mask),
        .opcode (op_d),
        .taken  (taken)
    );

    // State and latched-opcode register.
    always_ff @(posedge clk) begin
        if (rst_f) begin
            state_q <= ST_START0;
            op_q    <= OP_NOP;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
        end
    end

    // Next-state selection.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_START0:  state_d = ST_FETCH;
            ST_FETCH:   state_d = ST_DECODE;
            ST_DECODE:  state_d = ST_EXECUTE;
            ST_EXECUTE: begin
                case (op_q)
                    OP_ALU_RR, OP_ALU_IMM: state_d = ST_WRITEBACK;
                    OP_LOAD, OP_STORE:     state_d = ST_MEM;
                    OP_HALT:               state_d = ST_HALT;
                    default:               state_d = ST_FETCH;
                endcase
            end
            ST_MEM: begin
`ifdef SISC_CTRL_MEMWAIT_EN
                if (!mem_rdy) state_d = ST_MEM;
                else
`endif
                state_d = (op_q == OP_LOAD) ? ST_WRITEBACK : ST_FETCH;
            end
            ST_WRITEBACK: state_d = ST_FETCH;
            ST_HALT:      state_d = ST_HALT;
            default:      state_d = ST_START0;
        endcase
    end

    // Output decode for the state about to be entered.
    always_comb begin
        ir_load_d  = 1'b0;
        pc_write_d = 1'b0;
        pc_sel_d   = 1'b0;
        br_sel_d   = 1'b0;
        rf_we_d    = 1'b0;
        wb_sel_d   = 1'b0;
        stat_en_d  = 1'b0;
        rb_sel_d   = 1'b0;
        mm_sel_d   = 1'b0;
        dm_we_d    = 1'b0;
        dm_re_d    = 1'b0;
        halted_d   = 1'b0;
        alu_op_d   = '0;
        case (state_d)
            ST_FETCH: begin
                ir_load_d  = 1'b1;
                pc_write_d = 1'b1;
                pc_sel_d   = 1'b0;
            end
            ST_EXECUTE: begin
                // Only reachable from DECODE, so ir is the instruction being decoded.
                if (op_d == OP_ALU_RR || op_d == OP_ALU_IMM) begin
                    stat_en_d = 1'b1;
                    alu_op_d  = ir[ALUOP_W-1:0];
                    rb_sel_d  = (op_d == OP_ALU_IMM);
                end
                if (taken) begin
                    pc_write_d = 1'b1;
                    pc_sel_d   = 1'b1;
                    br_sel_d   = ir_br;
                end
            end
            ST_MEM: begin
                mm_sel_d = 1'b1;
                dm_re_d  = (op_d == OP_LOAD);
                dm_we_d  = (op_d == OP_STORE);
            end
            ST_WRITEBACK: begin
                rf_we_d  = 1'b1;
                wb_sel_d = (op_d == OP_LOAD);
            end
            ST_HALT: halted_d = 1'b1;
            default: ;
        endcase
    end

    // Output register; reset clears every enable.
    always_ff @(posedge clk) begin
        if (rst_f) begin
            ir_load  <= 1'b0;
            pc_write <= 1'b0;
            pc_sel   <= 1'b0;
            br_sel   <= 1'b0;
            rf_we    <= 1'b0;
            wb_sel   <= 1'b0;
            stat_en  <= 1'b0;
            rb_sel   <= 1'b0;
            mm_sel   <= 1'b0;
            dm_we    <= 1'b0;
            dm_re    <= 1'b0;
            alu_op   <= '0;
            halted   <= 1'b0;
        end else begin
            ir_load  <= ir_load_d;
            pc_write <= pc_write_d;
            pc_sel   <= pc_sel_d;
            br_sel   <= br_sel_d;
            rf_we    <= rf_we_d;
            wb_sel   <= wb_sel_d;
            stat_en  <= stat_en_d;
            rb_sel   <= rb_sel_d;
            mm_sel   <= mm_sel_d;
            dm_we    <= dm_we_d;
            dm_re    <= dm_re_d;
            alu_op   <= alu_op_d;
            halted   <= halted_d;
        end
    end

endmodule
